branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Parametrised branch resolution and prediction block for the 5-stage MIPS pipeline.
- Supersedes flag-based condition evaluation. Compares full-width rs/rt operands directly in EX for all conditional MIPS branches (BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL/BAL).
- Holds a PHT of 2-bit saturating counters that ID queries for prediction.
- Registers the resolved outcome, link request and mispredict/flush one cycle after EX.

Parameters:
DATA_W, 32, operand width for rs/rt compare
PHT_DEPTH, 64, number of 2-bit predictor entries; power of 2, >=2
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  pipeline clock, rising edge
reset_n  in  1  asynchronous active-low reset
id_pc  in  32  PC of instruction in ID, used for PHT lookup
id_pred_taken  out  1  combinational prediction: PHT[idx(id_pc)][1]
ex_valid  in  1  EX stage holds a valid instruction
ex_instr  in  32  instruction word in EX
ex_pc  in  32  PC of instruction in EX
ex_rs_val  in  DATA_W  forwarded rs value
ex_rt_val  in  DATA_W  forwarded rt value
ex_pred_taken  in  1  prediction carried down from ID
res_valid  out  1  registered: resolved branch present
res_taken  out  1  registered: branch condition true
res_link  out  1  registered: write PC+8 to $31
res_mispredict  out  1  registered: res_taken != ex_pred_taken
res_flush  out  1  registered: equals res_mispredict
branch_cnt  out  CNT_W  resolved branch count (optional feature)
mispred_cnt  out  CNT_W  mispredict count (optional feature)

Behaviour:
- Decode (EX, combinational). is_branch is true for exactly these encodings:
  - op=000100 BEQ; op=000101 BNE.
  - op=000110 BLEZ and op=000111 BGTZ, both only with rt field=00000.
  - op=000001 with rt field in {00000 BLTZ, 00001 BGEZ, 10000 BLTZAL, 10001 BGEZAL}.
  - All other encodings, including REGIMM with other rt codes, are non-branch.
- Conditions use signed DATA_W compares:
  - BEQ: rs==rt. BNE: rs!=rt.
  - BLEZ: rs<=0. BGTZ: rs>0.
  - BLTZ/BLTZAL: rs<0. BGEZ/BGEZAL: rs>=0.
  - BAL is BGEZAL with rs=$0 and must resolve taken with no special case.
- link = BLTZAL or BGEZAL. Asserted whether or not the branch is taken.
- Latency: exactly 1 cycle. On each rising edge, if ex_valid & is_branch:
  - res_valid<=1, res_taken<=cond, res_link<=link.
  - res_mispredict<=res_flush<=(cond != ex_pred_taken).
- Otherwise all res_* <= 0. No output holds across cycles.
- PHT:
  - idx(pc) = pc[log2(PHT_DEPTH)+1:2].
  - Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - On the same edge as a valid resolution, PHT[idx(ex_pc)] increments if cond, else decrements.
  - Saturates at 11 and 00; no wrap.
  - No update when ex_valid=0 or the instruction is non-branch.
- Read-during-write: if id_pc and ex_pc hit the same index in one cycle, id_pred_taken shows the pre-update value. No bypass.
- Reset (async, reset_n=0), any time including mid-branch:
  - all res_* = 0; every PHT entry = 01; counters = 0.
  - id_pred_taken is therefore 0 immediately.
  - Outputs stay in reset state until the first rising edge after deassertion.
- PC bits [1:0] and [31:log2(PHT_DEPTH)+2] are ignored; aliasing between PCs is permitted.

Optional Feature:
- Macro: BRU_STATS_EN.
- Defined:
  - branch_cnt increments by 1 on every edge with a valid resolution.
  - mispred_cnt increments by 1 when res_mispredict is being set.
  - Both saturate at 2^CNT_W-1 and clear on reset.
- Undefined: branch_cnt and mispred_cnt are tied to 0 and no counter flops are synthesised.

Test Plan:
1. Reset, then id_pc=0x40 -> id_pred_taken=0. With ex_valid=1, BEQ, rs=rt=5, ex_pred_taken=0 -> next cycle res_valid=1, res_taken=1, res_mispredict=1, res_flush=1. PHT[16]=10.
2. Three consecutive taken BNE at ex_pc=0x80 (rs=1, rt=2) starting from 01 -> PHT[32] goes 10, 11, 11 (saturates). id_pc=0x80 -> id_pred_taken=1. A fourth resolution with rs=rt -> PHT[32]=10.
3. BLTZAL with rs=0x00000001, and BGEZAL with rs=$0 (BAL), rs=0 -> both res_link=1. res_taken=0 for BLTZAL, 1 for BAL.
4. Signed boundary: BGTZ rs=0x80000000 -> taken=0. BLEZ rs=0x80000000 -> taken=1. BGEZ rs=0x7FFFFFFF -> taken=1.
5. Malformed BLEZ (rt=00011), REGIMM rt=00010, and ADDI with ex_valid=1 -> res_valid=0, all res_*=0, PHT unchanged.
6. reset_n pulsed low mid-cycle after PHT training -> res_* drop to 0 asynchronously, all PHT entries=01, counters=0 (BRU_STATS_EN). With the macro: 5 resolutions including 2 mispredicts -> branch_cnt=5, mispred_cnt=2.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage MIPS branch resolver with a 2-bit PHT predictor; BRU_STATS_EN adds branch/mispredict counters
module branch_resolve_unit #(
   parameter int DATA_W    = 32,
   parameter int PHT_DEPTH = 64,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [31:0]       id_pc,
   output logic              id_pred_taken,
   input  logic              ex_valid,
   input  logic [31:0]       ex_instr,
   input  logic [31:0]       ex_pc,
   input  logic [DATA_W-1:0] ex_rs_val,
   input  logic [DATA_W-1:0] ex_rt_val,
   input  logic              ex_pred_taken,
   output logic              res_valid,
   output logic              res_taken,
   output logic              res_link,
   output logic              res_mispredict,
   output logic              res_flush,
   output logic [CNT_W-1:0]  branch_cnt,
   output logic [CNT_W-1:0]  mispred_cnt
);
   localparam int IDX_W = $clog2(PHT_DEPTH);

   logic [1:0]       pht [PHT_DEPTH];
   logic [IDX_W-1:0] id_idx, ex_idx;
   logic [5:0]       op;
   logic [4:0]       rt_f;
   logic             rs_neg, rs_zero, is_branch, cond, link, resolve;
   logic [1:0]       pht_cur, pht_next;
   logic             unused_bits;

   assign id_idx        = id_pc[IDX_W+1:2];
   assign ex_idx        = ex_pc[IDX_W+1:2];
   assign op            = ex_instr[31:26];
   assign rt_f          = ex_instr[20:16];
   assign rs_neg        = ex_rs_val[DATA_W-1];
   assign rs_zero       = ex_rs_val == '0;
   assign resolve       = ex_valid & is_branch;
   assign id_pred_taken = pht[id_idx][1];
   assign pht_cur       = pht[ex_idx];
   assign pht_next      = cond ? ((pht_cur == 2'b11) ? pht_cur : pht_cur + 2'b01)
                               : ((pht_cur == 2'b00) ? pht_cur : pht_cur - 2'b01);
   assign unused_bits   = ^{id_pc[31:IDX_W+2], id_pc[1:0], ex_pc[31:IDX_W+2], ex_pc[1:0],
                            ex_instr[25:21], ex_instr[15:0]};

   // decode the EX instruction and evaluate its branch condition as a signed compare against rt or zero
   always_comb begin
      is_branch = 1'b0;
      cond      = 1'b0;
      link      = 1'b0;
      case (op)
         6'b000100: begin is_branch = 1'b1;           cond = ex_rs_val == ex_rt_val; end
         6'b000101: begin is_branch = 1'b1;           cond = ex_rs_val != ex_rt_val; end
         6'b000110: begin is_branch = rt_f == 5'd0;   cond = rs_neg | rs_zero; end
         6'b000111: begin is_branch = rt_f == 5'd0;   cond = ~rs_neg & ~rs_zero; end
         6'b000001: begin
            is_branch = rt_f[3:1] == 3'b000;
            cond      = rt_f[0] ? ~rs_neg : rs_neg;
            link      = rt_f[4] & is_branch;
         end
         default: ;
      endcase
   end

   // register the resolution for exactly one cycle; non-branches clear every result
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         res_valid      <= 1'b0;
         res_taken      <= 1'b0;
         res_link       <= 1'b0;
         res_mispredict <= 1'b0;
         res_flush      <= 1'b0;
      end else begin
         res_valid      <= resolve;
         res_taken      <= resolve & cond;
         res_link       <= resolve & link;
         res_mispredict <= resolve & (cond != ex_pred_taken);
         res_flush      <= resolve & (cond != ex_pred_taken);
      end
   end

   // train the saturating counter of the resolved branch; reset leaves every entry weakly not-taken
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= 2'b01;
      end else if (resolve) begin
         pht[ex_idx] <= pht_next;
      end
   end

`ifdef BRU_STATS_EN
   // saturating statistics for resolved branches and mispredictions
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else if (resolve) begin
         branch_cnt  <= (branch_cnt == '1) ? branch_cnt : branch_cnt + 1'b1;
         mispred_cnt <= (cond == ex_pred_taken || mispred_cnt == '1) ? mispred_cnt : mispred_cnt + 1'b1;
      end
   end
`else
   assign branch_cnt  = '0;
   assign mispred_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and randomized checks of branch_resolve_unit against a behavioural model
module tb_branch_resolve_unit;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic [31:0] id_pc = '0, ex_instr = '0, ex_pc = '0, ex_rs_val = '0, ex_rt_val = '0;
   logic        ex_valid = 1'b0, ex_pred_taken = 1'b0;
   logic        id_pred_taken, res_valid, res_taken, res_link, res_mispredict, res_flush;
   logic [15:0] branch_cnt, mispred_cnt;
   int          checks = 0, errors = 0;
   int          pht_m [64];
   int          bcnt_m = 0, mcnt_m = 0;

   branch_resolve_unit dut (
      .clk(clk), .reset_n(reset_n), .id_pc(id_pc), .id_pred_taken(id_pred_taken),
      .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc(ex_pc), .ex_rs_val(ex_rs_val),
      .ex_rt_val(ex_rt_val), .ex_pred_taken(ex_pred_taken), .res_valid(res_valid),
      .res_taken(res_taken), .res_link(res_link), .res_mispredict(res_mispredict),
      .res_flush(res_flush), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   // kinds: 0 BEQ 1 BNE 2 BLEZ 3 BGTZ 4 BLTZ 5 BGEZ 6 BLTZAL 7 BGEZAL
   //        8 BLEZ bad rt 9 BGTZ bad rt 10 REGIMM other rt 11 ADDI 12 R-type
   function automatic logic [31:0] enc(int kind);
      logic [31:0] w;
      logic [4:0]  r;
      w = $urandom;
      case (kind)
         0: w[31:26] = 6'd4;
         1: w[31:26] = 6'd5;
         2: begin w[31:26] = 6'd6; w[20:16] = 5'd0; end
         3: begin w[31:26] = 6'd7; w[20:16] = 5'd0; end
         4: begin w[31:26] = 6'd1; w[20:16] = 5'd0; end
         5: begin w[31:26] = 6'd1; w[20:16] = 5'd1; end
         6: begin w[31:26] = 6'd1; w[20:16] = 5'd16; end
         7: begin w[31:26] = 6'd1; w[20:16] = 5'd17; end
         8: begin w[31:26] = 6'd6; w[20:16] = 5'($urandom_range(1, 31)); end
         9: begin w[31:26] = 6'd7; w[20:16] = 5'($urandom_range(1, 31)); end
         10: begin
            r = 5'($urandom_range(2, 15));
            if ($urandom_range(0, 1) == 1) r = r + 5'd16;
            w[31:26] = 6'd1; w[20:16] = r;
         end
         11: w[31:26] = 6'd8;
         default: w[31:26] = 6'd0;
      endcase
      return w;
   endfunction

   function automatic bit taken_of(int kind, logic [31:0] rs, logic [31:0] rt);
      int s;
      s = int'(rs);
      case (kind)
         0: return rs == rt;
         1: return rs != rt;
         2: return s <= 0;
         3: return s > 0;
         4, 6: return s < 0;
         5, 7: return s >= 0;
         default: return 0;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) pht_m[i] = 1;
      bcnt_m = 0;
      mcnt_m = 0;
   endtask

   task automatic chk_cnt();
`ifdef BRU_STATS_EN
      chk("branch_cnt", 32'(branch_cnt), 32'(bcnt_m));
      chk("mispred_cnt", 32'(mispred_cnt), 32'(mcnt_m));
`else
      chk("branch_cnt", 32'(branch_cnt), 0);
      chk("mispred_cnt", 32'(mispred_cnt), 0);
`endif
   endtask

   task automatic step(int kind, logic [31:0] rs, logic [31:0] rt, bit pred, logic [31:0] pc,
                       bit valid, logic [31:0] ipc);
      bit br, t, lk, res;
      int ix;
      @(negedge clk);
      ex_instr = enc(kind); ex_rs_val = rs; ex_rt_val = rt; ex_pred_taken = pred;
      ex_pc = pc; ex_valid = valid; id_pc = ipc;
      #1;
      chk("id_pred_taken", 32'(id_pred_taken), 32'(pht_m[ipc[7:2]] >= 2));
      br  = kind <= 7;
      res = valid && br;
      t   = taken_of(kind, rs, rt);
      lk  = kind == 6 || kind == 7;
      @(posedge clk);
      #1;
      chk("res_valid", 32'(res_valid), 32'(res));
      chk("res_taken", 32'(res_taken), 32'(res && t));
      chk("res_link", 32'(res_link), 32'(res && lk));
      chk("res_mispredict", 32'(res_mispredict), 32'(res && t != pred));
      chk("res_flush", 32'(res_flush), 32'(res && t != pred));
      if (res) begin
         ix = int'(pc[7:2]);
         pht_m[ix] = t ? ((pht_m[ix] < 3) ? pht_m[ix] + 1 : 3) : ((pht_m[ix] > 0) ? pht_m[ix] - 1 : 0);
         bcnt_m++;
         if (t != pred) mcnt_m++;
      end
      chk_cnt();
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] rs, rt, pc;
      model_reset();
      id_pc = 32'h40;
      #1;
      chk("reset_res_valid", 32'(res_valid), 0);
      chk("reset_res_flush", 32'(res_flush), 0);
      chk("reset_pred_40", 32'(id_pred_taken), 0);
      chk_cnt();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      // 1: BEQ taken while predicted not-taken
      step(0, 32'd5, 32'd5, 0, 32'h40, 1, 32'h40);
      step(11, 0, 0, 0, 0, 0, 32'h40);
      // 2: training 0x80 to saturation then back down
      step(1, 32'd1, 32'd2, 0, 32'h80, 1, 32'h80);
      step(1, 32'd1, 32'd2, 1, 32'h80, 1, 32'h80);
      step(1, 32'd1, 32'd2, 1, 32'h80, 1, 32'h80);
      step(1, 32'd7, 32'd7, 1, 32'h80, 1, 32'h80);
      step(1, 32'd7, 32'd7, 1, 32'h80, 1, 32'h80);
      step(1, 32'd7, 32'd7, 0, 32'h80, 1, 32'h80);
      // 3: linking branches, including BAL
      step(6, 32'h1, 32'h0, 0, 32'h100, 1, 32'h100);
      step(7, 32'h0, 32'h0, 0, 32'h104, 1, 32'h104);
      // 4: signed boundaries
      step(3, 32'h8000_0000, 0, 1, 32'h10, 1, 32'h10);
      step(2, 32'h8000_0000, 0, 0, 32'h14, 1, 32'h14);
      step(5, 32'h7FFF_FFFF, 0, 0, 32'h18, 1, 32'h18);
      step(2, 32'h0, 0, 0, 32'h1C, 1, 32'h1C);
      step(4, 32'h0, 0, 1, 32'h1C, 1, 32'h1C);
      // 5: malformed and non-branch encodings leave PHT untouched
      step(8, 32'h8000_0000, 0, 1, 32'h200, 1, 32'h200);
      step(10, 32'h8000_0000, 0, 1, 32'h200, 1, 32'h200);
      step(11, 32'h0, 0, 1, 32'h200, 1, 32'h200);
      step(9, 32'h1, 0, 0, 32'h200, 1, 32'h200);
      step(0, 32'h1, 32'h1, 1, 32'h200, 0, 32'h200);
      step(12, 32'h1, 32'h1, 1, 32'h200, 1, 32'h200);
      // randomized traffic across a few aliasing PCs
      for (int n = 0; n < 300; n++) begin
         rs = pick_val();
         rt = ($urandom_range(0, 3) == 0) ? rs : pick_val();
         pc = {22'($urandom), 4'($urandom_range(0, 3)), 6'($urandom)};
         step($urandom_range(0, 12), rs, rt, 1'($urandom), pc, $urandom_range(0, 4) != 0,
              {24'($urandom), 2'b0, 4'($urandom_range(0, 3)), 2'($urandom)});
      end
      // 6: asynchronous reset mid-cycle right after a resolution
      step(0, 32'd3, 32'd3, 0, 32'h80, 1, 32'h80);
      #2 reset_n = 1'b0;
      #1;
      chk("async_res_valid", 32'(res_valid), 0);
      chk("async_res_taken", 32'(res_taken), 0);
      chk("async_res_mispredict", 32'(res_mispredict), 0);
      chk("async_pred_80", 32'(id_pred_taken), 0);
      model_reset();
      chk_cnt();
      ex_valid = 1'b0;
      for (int i = 0; i < 64; i++) begin
         id_pc = 32'(i * 4);
         #1;
         chk("reset_pht_pred", 32'(id_pred_taken), 0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      step(0, 32'd1, 32'd1, 1, 32'h80, 1, 32'h80);
      step(0, 32'd1, 32'd2, 1, 32'h80, 1, 32'h80);
      step(5, 32'd0, 32'd0, 1, 32'h84, 1, 32'h80);
      step(4, 32'd0, 32'd0, 1, 32'h88, 1, 32'h84);
      step(1, 32'd1, 32'd2, 1, 32'h8C, 1, 32'h88);
      step(11, 32'd0, 32'd0, 0, 32'h80, 0, 32'h80);
`ifdef BRU_STATS_EN
      chk("stats_branch_5", 32'(branch_cnt), 5);
      chk("stats_mispred_2", 32'(mispred_cnt), 2);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
